bottling_controller: RTL and testbench
======================================

Name: bottling_controller

Overview:
- Parametrised successor to the pill-bottling mode controller.
- Keeps the five-state flow: setting, working, pause, error, final.
- Adds internal pill and bottle counting against latched targets, a no-pill watchdog timeout, spurious-pill detection while paused, and an error-cause code.
- Sits between the sensor/keypad front end and the display/motor drivers; completion and error are generated internally, not supplied from outside.

Parameters:
- PILL_W, 6: width of the pills-per-bottle target and of pill_count.
- BOTTLE_W, 8: width of the bottle target and of bottle_count.
- TIMEOUT_CYCLES, 1000: clock cycles without a pill in working before a timeout error; must be ≥ 2.
- TIMEOUT_W, $clog2(TIMEOUT_CYCLES+1): watchdog counter width (derived).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- switch_pulse  in  1  single-cycle start/pause/resume/acknowledge request (already debounced).
- pill_pulse  in  1  single-cycle, one pulse per pill detected.
- error_in  in  1  external fault level (jam, bottle missing).
- pills_per_bottle  in  PILL_W  target pills per bottle; sampled on start.
- bottle_target  in  BOTTLE_W  target bottle count; sampled on start.
- state  out  state_t  current state.
- pill_count  out  PILL_W  pills in the current bottle.
- bottle_count  out  BOTTLE_W  bottles completed.
- bottle_done  out  1  one-cycle pulse when a bottle fills.
- motor_enable  out  1  high only in working.
- err_code  out  err_code_t  cause of the last error: NONE, CFG, EXT, TIMEOUT, SPURIOUS.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (at a clock edge with reset=1):
  - state=setting; all counters 0; latched targets 0.
  - bottle_done=0; err_code=NONE; motor_enable=0.
  - Reset overrides every other input, including mid-operation.
- Output timing: all outputs are registered. motor_enable is decoded from the registered state, so it is valid in the cycle the state takes effect.
- setting:
  - switch_pulse with pills_per_bottle==0 or bottle_target==0 → error, err_code=CFG.
  - Otherwise: latch both targets, clear pill_count, bottle_count and the watchdog, set err_code=NONE → working.
  - Counts from the previous run stay visible in setting until the next start.
- working — priority per cycle, highest first:
  1. error_in → error, err_code=EXT. A pill in the same cycle is not counted.
  2. Watchdog reaches TIMEOUT_CYCLES-1 with no pill in that cycle → error, err_code=TIMEOUT.
  3. pill_pulse:
     - watchdog←0.
     - If pill_count==ppb-1: pill_count←0, bottle_count+1, bottle_done=1 for one cycle.
     - If the incremented bottle_count == target → final. Completion wins over a simultaneous switch_pulse.
     - Otherwise pill_count+1.
  4. switch_pulse → pause. A pill counted in the same cycle still counts.
  - The watchdog increments every working cycle without a pill.
- pause:
  - motor_enable=0; watchdog held at 0.
  - error_in → error, EXT.
  - pill_pulse → error, SPURIOUS; the pill is not counted.
  - switch_pulse → working, watchdog restarts from 0.
- error:
  - Counts frozen; err_code held.
  - switch_pulse → setting. err_code keeps its value until the next successful start.
- final:
  - Counts frozen; switch_pulse → setting.
- Illegal state encoding → setting on the next edge.
- Width rules:
  - Counters never wrap: bottle_count ≤ target, pill_count < ppb.
  - A ppb of 1 completes a bottle on every pill.
  - A timeout on the exact cycle a pill arrives does not fire.

Decomposition:
- Shared package bottling_pkg holds:
  - state_t (setting, working, pause, error, final), extended from the existing definition;
  - err_code_t (3-bit enum);
  - no other constants.
- One sub-module, watchdog_timer:
  - parameter TIMEOUT_CYCLES;
  - inputs clock, reset, run, clear;
  - output expired, asserted combinationally when count==TIMEOUT_CYCLES-1 and run=1.
- The FSM and counters stay in bottling_controller.

Test Plan:
- Reset mid-working: assert reset with pill_count=3 → next edge gives state=setting, counts 0, err_code=NONE, motor_enable=0.
- Normal run: ppb=3, target=2, start, 6 pills spaced 10 cycles apart → bottle_done pulses after pills 3 and 6; state=final on the 6th pill's edge; bottle_count=2; then switch → setting.
- Config error: ppb=0, switch → error with err_code=CFG; switch again → setting.
- Timeout: TIMEOUT_CYCLES=16, start, no pills → error with err_code=TIMEOUT exactly 16 cycles after entering working; a pill on cycle 15 → no error, watchdog restarts.
- Pause behaviour: working, switch → pause with motor_enable=0; 100 idle cycles give no timeout; a pill → error with SPURIOUS and pill_count unchanged; separately, switch → working resumes counting.
- Simultaneous events: last pill + switch in the same cycle → final (not pause); error_in + pill in the same cycle → error, EXT, pill_count unchanged.

Source files
------------

// File: rtl/bottling_pkg.sv
// Shared types for the pill-bottling controller: mode states and error causes.
package bottling_pkg;

  typedef enum logic [2:0] {
    ST_SETTING = 3'd0,
    ST_WORKING = 3'd1,
    ST_PAUSE   = 3'd2,
    ST_ERROR   = 3'd3,
    ST_FINAL   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_CFG      = 3'd1,
    ERR_EXT      = 3'd2,
    ERR_TIMEOUT  = 3'd3,
    ERR_SPURIOUS = 3'd4
  } err_code_t;

endpackage

// File: rtl/bottling_controller_watchdog_timer.sv
// No-pill watchdog: counts run cycles, flags the cycle the count sits at TIMEOUT_CYCLES-1.
module watchdog_timer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] count;

  // Count run cycles; clear wins, and the count parks at LAST so it can never wrap.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != LAST)) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  assign expired = run && (count == LAST);

endmodule

// File: rtl/bottling_controller.sv
// Pill-bottling mode controller: setting/working/pause/error/final flow with
// internal pill and bottle counting, no-pill watchdog and error-cause reporting.
module bottling_controller
  import bottling_pkg::*;
#(
  parameter int PILL_W         = 6,
  parameter int BOTTLE_W       = 8,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                switch_pulse,
  input  logic                pill_pulse,
  input  logic                error_in,
  input  logic [PILL_W-1:0]   pills_per_bottle,
  input  logic [BOTTLE_W-1:0] bottle_target,
  output state_t              state,
  output logic [PILL_W-1:0]   pill_count,
  output logic [BOTTLE_W-1:0] bottle_count,
  output logic                bottle_done,
  output logic                motor_enable,
  output err_code_t           err_code
);

  logic [PILL_W-1:0]   ppb_q,  ppb_n;
  logic [BOTTLE_W-1:0] tgt_q,  tgt_n;
  logic [PILL_W-1:0]   pill_n;
  logic [BOTTLE_W-1:0] bottle_n, bottle_inc;
  state_t              state_n;
  err_code_t           err_n;
  logic                done_n;
  logic                wd_run, wd_clear, wd_expired;

  // Watchdog only advances in working; any pill or any other state restarts it from 0.
  assign wd_run   = (state == ST_WORKING);
  assign wd_clear = (state != ST_WORKING) || pill_pulse;

  watchdog_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .run     (wd_run),
    .clear   (wd_clear),
    .expired (wd_expired)
  );

  assign bottle_inc   = bottle_count + BOTTLE_W'(1);
  assign motor_enable = (state == ST_WORKING);

  // Next-state, counter and error-code decisions for the current mode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_n  = state;
    pill_n   = pill_count;
    bottle_n = bottle_count;
    done_n   = 1'b0;
    err_n    = err_code;
    ppb_n    = ppb_q;
    tgt_n    = tgt_q;

    case (state)
      ST_SETTING: begin
        if (switch_pulse) begin
          if ((pills_per_bottle == '0) || (bottle_target == '0)) begin
            state_n = ST_ERROR;
            err_n   = ERR_CFG;
          end else begin
            ppb_n    = pills_per_bottle;
            tgt_n    = bottle_target;
            pill_n   = '0;
            bottle_n = '0;
            err_n    = ERR_NONE;
            state_n  = ST_WORKING;
          end
        end
      end

      ST_WORKING: begin
        if (error_in) begin
          state_n = ST_ERROR;
          err_n   = ERR_EXT;
        end else if (wd_expired && !pill_pulse) begin
          state_n = ST_ERROR;
          err_n   = ERR_TIMEOUT;
        end else begin
          if (pill_pulse) begin
            if (pill_count == ppb_q - PILL_W'(1)) begin
              pill_n   = '0;
              bottle_n = bottle_inc;
              done_n   = 1'b1;
              if (bottle_inc == tgt_q) begin
                state_n = ST_FINAL;
              end
            end else begin
              pill_n = pill_count + PILL_W'(1);
            end
          end
          // Completion outranks a pause request arriving in the same cycle.
          if (switch_pulse && (state_n == ST_WORKING)) begin
            state_n = ST_PAUSE;
          end
        end
      end

      ST_PAUSE: begin
        if (error_in) begin
          state_n = ST_ERROR;
          err_n   = ERR_EXT;
        end else if (pill_pulse) begin
          state_n = ST_ERROR;
          err_n   = ERR_SPURIOUS;
        end else if (switch_pulse) begin
          state_n = ST_WORKING;
        end
      end

      ST_ERROR, ST_FINAL: begin
        if (switch_pulse) begin
          state_n = ST_SETTING;
        end
      end

      default: state_n = ST_SETTING;
    endcase
  end

  // Register state, counters, latched targets and the bottle_done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_SETTING;
      pill_count   <= '0;
      bottle_count <= '0;
      bottle_done  <= 1'b0;
      err_code     <= ERR_NONE;
      ppb_q        <= '0;
      tgt_q        <= '0;
    end else begin
      state        <= state_n;
      pill_count   <= pill_n;
      bottle_count <= bottle_n;
      bottle_done  <= done_n;
      err_code     <= err_n;
      ppb_q        <= ppb_n;
      tgt_q        <= tgt_n;
    end
  end

endmodule

// File: tb/tb_bottling_controller.sv
// Self-checking bench for bottling_controller: directed scenarios plus random
// traffic, every cycle compared against a behavioural reference model.
module tb_bottling_controller;
  import bottling_pkg::*;

  localparam int T = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       switch_pulse = 1'b0;
  logic       pill_pulse = 1'b0;
  logic       error_in = 1'b0;
  logic [5:0] pills_per_bottle = '0;
  logic [7:0] bottle_target = '0;
  state_t     state;
  logic [5:0] pill_count;
  logic [7:0] bottle_count;
  logic       bottle_done;
  logic       motor_enable;
  err_code_t  err_code;

  bottling_controller #(
    .PILL_W (6), .BOTTLE_W (8), .TIMEOUT_CYCLES (T)
  ) dut (
    .clock (clock), .reset (reset), .switch_pulse (switch_pulse),
    .pill_pulse (pill_pulse), .error_in (error_in),
    .pills_per_bottle (pills_per_bottle), .bottle_target (bottle_target),
    .state (state), .pill_count (pill_count), .bottle_count (bottle_count),
    .bottle_done (bottle_done), .motor_enable (motor_enable), .err_code (err_code)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode plus plain integer counts.
  state_t    m_state;
  err_code_t m_err;
  int        m_pills, m_bottles, m_ppb, m_tgt, m_idle;
  bit        m_done;

  task automatic model_step();
    if (reset) begin
      m_state = ST_SETTING; m_err = ERR_NONE; m_pills = 0; m_bottles = 0;
      m_ppb = 0; m_tgt = 0; m_idle = 0; m_done = 0;
      return;
    end
    m_done = 0;
    case (m_state)
      ST_SETTING: if (switch_pulse) begin
        if (pills_per_bottle == 0 || bottle_target == 0) begin
          m_state = ST_ERROR; m_err = ERR_CFG;
        end else begin
          m_ppb = pills_per_bottle; m_tgt = bottle_target;
          m_pills = 0; m_bottles = 0; m_idle = 0; m_err = ERR_NONE;
          m_state = ST_WORKING;
        end
      end
      ST_WORKING: begin
        if (error_in) begin
          m_state = ST_ERROR; m_err = ERR_EXT;
        end else if (!pill_pulse && m_idle == T - 1) begin
          m_state = ST_ERROR; m_err = ERR_TIMEOUT;
        end else begin
          if (pill_pulse) begin
            m_idle = 0;
            m_pills++;
            if (m_pills == m_ppb) begin
              m_pills = 0; m_bottles++; m_done = 1;
              if (m_bottles == m_tgt) m_state = ST_FINAL;
            end
          end else begin
            m_idle++;
          end
          if (switch_pulse && m_state == ST_WORKING) m_state = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (error_in) begin
          m_state = ST_ERROR; m_err = ERR_EXT;
        end else if (pill_pulse) begin
          m_state = ST_ERROR; m_err = ERR_SPURIOUS;
        end else if (switch_pulse) begin
          m_state = ST_WORKING;
        end
      end
      default: if (switch_pulse) m_state = ST_SETTING;
    endcase
    if (m_state != ST_WORKING) m_idle = 0;
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    check("state", state, m_state);
    check("pill_count", pill_count, m_pills);
    check("bottle_count", bottle_count, m_bottles);
    check("bottle_done", bottle_done, m_done);
    check("err_code", err_code, m_err);
    check("motor_enable", motor_enable, m_state == ST_WORKING);
  endtask

  task automatic cyc(input logic sw, input logic pl, input logic er);
    switch_pulse = sw; pill_pulse = pl; error_in = er;
    step();
    switch_pulse = 1'b0; pill_pulse = 1'b0; error_in = 1'b0;
  endtask

  task automatic start(input int ppb, input int tgt);
    pills_per_bottle = 6'(ppb); bottle_target = 8'(tgt);
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    bit pill_on;

    // Reset state
    step(); step();
    reset = 1'b0;
    check("rst_state", state, ST_SETTING);
    check("rst_motor", motor_enable, 1'b0);

    // Reset mid-working with three pills counted
    start(5, 3);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    check("mid_pills", pill_count, 3);
    reset = 1'b1; step(); reset = 1'b0;
    check("mid_rst_state", state, ST_SETTING);
    check("mid_rst_pills", pill_count, 0);
    check("mid_rst_err", err_code, ERR_NONE);
    check("mid_rst_motor", motor_enable, 1'b0);

    // Normal run: 3 pills per bottle, 2 bottles
    start(3, 2);
    for (int p = 1; p <= 6; p++) begin
      repeat (9) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      check("run_done", bottle_done, (p % 3) == 0);
    end
    check("run_final", state, ST_FINAL);
    check("run_bottles", bottle_count, 2);
    cyc(1'b1, 1'b0, 1'b0);
    check("run_back_setting", state, ST_SETTING);
    check("run_count_kept", bottle_count, 2);

    // Config error
    start(0, 4);
    check("cfg_state", state, ST_ERROR);
    check("cfg_err", err_code, ERR_CFG);
    cyc(1'b1, 1'b0, 1'b0);
    check("cfg_setting", state, ST_SETTING);
    check("cfg_err_kept", err_code, ERR_CFG);

    // Timeout with no pills
    start(4, 2);
    n = 0;
    while (state == ST_WORKING && n < 40) begin cyc(1'b0, 1'b0, 1'b0); n++; end
    check("to_cycles", n, T);
    check("to_err", err_code, ERR_TIMEOUT);

    // Pill on the timeout cycle suppresses it and restarts the watchdog
    cyc(1'b1, 1'b0, 1'b0);
    start(4, 2);
    repeat (T - 1) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check("to_pill_state", state, ST_WORKING);
    check("to_pill_count", pill_count, 1);
    n = 0;
    while (state == ST_WORKING && n < 40) begin cyc(1'b0, 1'b0, 1'b0); n++; end
    check("to_restart_cycles", n, T);

    // Pause: no timeout, spurious pill
    cyc(1'b1, 1'b0, 1'b0);
    start(5, 3);
    repeat (2) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("pause_state", state, ST_PAUSE);
    check("pause_motor", motor_enable, 1'b0);
    repeat (100) cyc(1'b0, 1'b0, 1'b0);
    check("pause_no_to", state, ST_PAUSE);
    cyc(1'b0, 1'b1, 1'b0);
    check("spur_state", state, ST_ERROR);
    check("spur_err", err_code, ERR_SPURIOUS);
    check("spur_pills", pill_count, 2);

    // Pause then resume keeps counting
    cyc(1'b1, 1'b0, 1'b0);
    start(5, 3);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("resume_state", state, ST_WORKING);
    cyc(1'b0, 1'b1, 1'b0);
    check("resume_pills", pill_count, 2);

    // Last pill + switch together -> final; ppb=1 fills on every pill
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    start(1, 1);
    cyc(1'b1, 1'b1, 1'b0);
    check("sim_final", state, ST_FINAL);
    check("sim_done", bottle_done, 1'b1);
    check("sim_bottles", bottle_count, 1);

    // error_in + pill together -> EXT, pill ignored
    cyc(1'b1, 1'b0, 1'b0);
    start(4, 2);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    check("ext_state", state, ST_ERROR);
    check("ext_err", err_code, ERR_EXT);
    check("ext_pills", pill_count, 1);

    // Random traffic
    pill_on = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) pill_on = ($urandom_range(0, 3) != 0);
      pills_per_bottle = 6'($urandom_range(0, 4));
      bottle_target    = 8'($urandom_range(0, 3));
      reset = ($urandom_range(0, 199) == 0);
      cyc($urandom_range(0, 11) == 0,
          pill_on && ($urandom_range(0, 2) == 0),
          $urandom_range(0, 59) == 0);
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
